// File: rtl/digi_pattern_source.sv
// Programmable interval pattern generator: toggles dout after each
// stored interval, once per start or looping continuously.
module digi_pattern_source #(
    parameter int INIT   = 0,
    parameter int DEPTH  = 8,
    parameter int CW     = 16,
    parameter int REPEAT = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [CW-1:0]                wr_data,
    input  logic                         start,
    input  logic                         stop,
    output logic                         dout,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int   CNTW   = $clog2(DEPTH + 1);
    localparam int   IW     = $clog2(DEPTH);
    localparam logic INIT_L = (INIT != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   mem [DEPTH];
    logic [IW-1:0]   idx, idx_n;
    logic [CW-1:0]   timer, timer_n;
    logic [CNTW-1:0] count_n;
    logic            dout_n;
    logic            done_n;
    logic            wr_fire;
    logic            last;
    logic            expire;

    assign wr_ready = (state == IDLE) && (count < CNTW'(DEPTH)) && !clr;
    assign wr_fire  = wr_valid && wr_ready;
    assign last     = (CNTW'(idx) == count - CNTW'(1));
    assign expire   = (timer == CW'(1));
    assign busy     = (state == RUN);

    // Next-state, datapath updates and pass-complete strobe
    always_comb begin
        state_n = state;
        idx_n   = idx;
        timer_n = timer;
        count_n = count;
        dout_n  = dout;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (clr) begin
                    count_n = '0;
                end else if (wr_fire) begin
                    count_n = count + CNTW'(1);
                end
                if (start && !stop && count != '0) begin
                    state_n = RUN;
                    idx_n   = '0;
                    timer_n = mem['0];
                    dout_n  = INIT_L;
                end
            end
            RUN: begin
                if (stop) begin
                    state_n = IDLE;
                    idx_n   = '0;
                    timer_n = '0;
                    dout_n  = INIT_L;
                end else if (expire) begin
                    dout_n = ~dout;
                    if (last) begin
                        done_n  = 1'b1;
                        idx_n   = '0;
                        timer_n = mem['0];
                        if (REPEAT == 0) begin
                            state_n = DONE;
                        end
                    end else begin
                        idx_n   = idx + IW'(1);
                        timer_n = mem[idx + IW'(1)];
                    end
                end else begin
                    timer_n = timer - CW'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Datapath registers: index, timer, level, fill count, done strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx   <= '0;
            timer <= '0;
            dout  <= INIT_L;
            count <= '0;
            done  <= 1'b0;
        end else begin
            idx   <= idx_n;
            timer <= timer_n;
            dout  <= dout_n;
            count <= count_n;
            done  <= done_n;
        end
    end

    // Interval buffer; a zero interval is stored as one cycle
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[count[IW-1:0]] <= (wr_data == '0) ? CW'(1) : wr_data;
        end
    end

endmodule

// File: tb/tb_digi_pattern_source.sv
// Randomized bench for digi_pattern_source: one-shot and looping
// instances checked against an interval-sum reference model.
module tb_digi_pattern_source;

    logic        clk = 1'b0;
    logic        rst, clr, wr_valid, start, stop;
    logic [15:0] wr_data;
    logic        a_ready, a_dout, a_busy, a_done;
    logic        b_ready, b_dout, b_busy, b_done;
    logic [3:0]  a_count, b_count;

    int checks = 0;
    int errors = 0;
    int q[$];

    always #5 clk = ~clk;

    digi_pattern_source #(.INIT(0), .DEPTH(8), .CW(16), .REPEAT(0)) u_a (
        .clk(clk), .rst(rst), .clr(clr), .wr_valid(wr_valid),
        .wr_ready(a_ready), .wr_data(wr_data), .start(start),
        .stop(stop), .dout(a_dout), .busy(a_busy), .done(a_done),
        .count(a_count)
    );

    digi_pattern_source #(.INIT(1), .DEPTH(8), .CW(16), .REPEAT(1)) u_b (
        .clk(clk), .rst(rst), .clr(clr), .wr_valid(wr_valid),
        .wr_ready(b_ready), .wr_data(wr_data), .start(start),
        .stop(stop), .dout(b_dout), .busy(b_busy), .done(b_done),
        .count(b_count)
    );

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int total();
        int t = 0;
        foreach (q[i]) t += q[i];
        return t;
    endfunction

    // toggles seen by edge k of a single pass
    function automatic int toggles_once(int k);
        int s = 0;
        int n = 0;
        foreach (q[i]) begin
            s += q[i];
            if (s <= k) n++;
        end
        return n;
    endfunction

    // toggles seen by edge k when the pattern repeats
    function automatic int toggles_loop(int k);
        int t = total();
        return (k / t) * q.size() + toggles_once(k % t);
    endfunction

    task automatic wr(int v);
        bit exp_rdy;
        exp_rdy  = (q.size() < 8);
        wr_data  = 16'(v);
        wr_valid = 1'b1;
        #1;
        chk("wr_ready", a_ready, exp_rdy);
        if (exp_rdy) q.push_back((v == 0) ? 1 : v);
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic load(int vals[$]);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        q.delete();
        foreach (vals[i]) wr(vals[i]);
        chk("count", a_count, q.size());
    endtask

    // one-shot pass on instance a; stop_at<0 runs to completion
    task automatic run_a(int stop_at);
        int t;
        t = total();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k <= t + 1; k++) begin
            if (k > 0) tick();
            if (k == stop_at) begin
                stop = 1'b1;
                tick();
                stop = 1'b0;
                chk("stop_busy", a_busy, 0);
                chk("stop_dout", a_dout, 0);
                chk("stop_done", a_done, 0);
                tick();
                chk("stop_done2", a_done, 0);
                return;
            end
            chk("a_dout", a_dout, toggles_once(k) % 2);
            chk("a_busy", a_busy, k < t);
            chk("a_done", a_done, k == t);
        end
        chk("a_count_kept", a_count, q.size());
    endtask

    task automatic run_b(int cycles);
        int t;
        t = total();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k <= cycles; k++) begin
            if (k > 0) tick();
            chk("b_dout", b_dout, 1 ^ (toggles_loop(k) % 2));
            chk("b_busy", b_busy, 1);
            chk("b_done", b_done, k > 0 && (k % t) == 0);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("b_stop_dout", b_dout, 1);
        chk("b_stop_busy", b_busy, 0);
    endtask

    initial begin
        int vals[$];
        int n;
        rst = 1'b1; clr = 1'b0; wr_valid = 1'b0; wr_data = '0;
        start = 1'b0; stop = 1'b0;
        #1;
        chk("rst_dout", a_dout, 0);
        chk("rst_bdout", b_dout, 1);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_count", a_count, 0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_ready", a_ready, 1);

        load('{3, 2, 1});
        run_a(-1);

        load('{1, 2, 3, 4, 5, 6, 7, 8, 9});
        chk("full_ready", a_ready, 0);
        run_a(-1);

        load('{0, 0});
        chk("zero_count", a_count, 2);
        run_a(-1);

        load('{});
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("empty_start", a_busy, 0);
        tick();
        chk("empty_start2", a_busy, 0);

        load('{1, 2});
        clr = 1'b1;
        wr_valid = 1'b1;
        wr_data = 16'd7;
        #1;
        chk("clr_ready", a_ready, 0);
        tick();
        clr = 1'b0;
        wr_valid = 1'b0;
        chk("clr_wr_count", a_count, 0);

        load('{2, 3});
        start = 1'b1;
        stop = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        chk("start_stop", a_busy, 0);

        for (int it = 0; it < 8; it++) begin
            vals.delete();
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) vals.push_back($urandom_range(0, 6));
            load(vals);
            run_a(-1);
        end

        for (int it = 0; it < 4; it++) begin
            vals.delete();
            n = $urandom_range(2, 6);
            for (int i = 0; i < n; i++) vals.push_back($urandom_range(1, 5));
            load(vals);
            run_a($urandom_range(1, total() - 1));
        end

        load('{3, 3});
        run_a(3);

        load('{5, 5});
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_dout", a_dout, 0);
        chk("mid_rst_count", a_count, 0);
        chk("mid_rst_busy", a_busy, 0);
        chk("mid_rst_done", a_done, 0);
        chk("mid_rst_bbusy", b_busy, 0);
        #1;
        rst = 1'b0;
        tick();
        chk("mid_rst_ready", a_ready, 1);
        chk("mid_rst_done2", a_done, 0);

        load('{2, 2});
        run_b(17);

        for (int it = 0; it < 3; it++) begin
            vals.delete();
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) vals.push_back($urandom_range(0, 4));
            load(vals);
            run_b(3 * total() + 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/digi_pattern_source.md
DIGI_PATTERN_SOURCE -- requirements
Module: digi_pattern_source

Interface
REQ-001 SHALL have parameter INIT, default 0: idle/start output level.
REQ-002 SHALL have parameter DEPTH, default 8: pattern buffer entries, legal 2..64.
REQ-003 SHALL have parameter CW, default 16: interval width in bits.
REQ-004 SHALL have parameter REPEAT, default 0: 1 = loop pattern indefinitely.
REQ-005 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-007 SHALL have port clr  input  1  synchronous buffer clear.
REQ-008 SHALL have port wr_valid  input  1  interval write request.
REQ-009 SHALL have port wr_ready  output  1  write acceptance.
REQ-010 SHALL have port wr_data  input  CW  interval length in clk cycles.
REQ-011 SHALL have port start  input  1  begin pattern.
REQ-012 SHALL have port stop  input  1  abort pattern.
REQ-013 SHALL have port dout  output  1  logic stream driving downstream gate inputs.
REQ-014 SHALL have port busy  output  1  high while in RUN.
REQ-015 SHALL have port done  output  1  pass-complete pulse.
REQ-016 SHALL have port count  output  clog2(DEPTH+1)  number of stored entries.

Function
REQ-017 SHALL implement states IDLE, RUN, DONE.
REQ-018 SHALL drive wr_ready = (state==IDLE) && (count<DEPTH) && !clr, combinationally.
REQ-019 SHALL store wr_data at index count and increment count on each edge with wr_valid && wr_ready.
REQ-020 SHALL store a wr_data value of 0 as 1.
REQ-021 SHALL set count to 0 on clr in IDLE; clr outside IDLE SHALL be ignored; a write SHALL NOT be accepted in a cycle with clr high.
REQ-022 SHALL, on start in IDLE with count>0 and stop low, enter RUN, set index to 0, load timer with entry 0, and load dout with INIT.
REQ-023 SHALL ignore start in IDLE when count==0, and ignore start in RUN or DONE.
REQ-024 SHALL, with edge 0 being the edge entering RUN, toggle dout at edges e0, e0+e1, ..., e0+...+e(count-1), where ei is entry i.
REQ-025 SHALL, at each toggle edge, advance the index and reload the timer with the next entry.
REQ-026 SHALL, when REPEAT=0, enter DONE at the final toggle edge, assert done for exactly that one cycle, and return to IDLE on the next edge with dout held at its final level.
REQ-027 SHALL, when REPEAT=1, wrap the index to 0 at the final toggle edge, remain in RUN, and pulse done for one cycle per completed pass.
REQ-028 SHALL, on stop in RUN, enter IDLE on the next edge with dout = INIT and no done pulse; stop SHALL take priority over a toggle scheduled on the same edge.
REQ-029 SHALL, when start and stop are both high in IDLE, remain in IDLE.
REQ-030 SHALL drive busy = (state==RUN) and SHALL NOT modify buffer contents or count during RUN or DONE.
REQ-031 SHALL implement the timer as a CW-bit down-counter with no wrap, since intervals are at least 1.

Reset
REQ-032 SHALL, on rst high, immediately and without clk set state=IDLE, dout=INIT, count=0, index=0, timer=0, busy=0, done=0.
REQ-033 SHALL, on reset asserted mid-RUN, abort the pattern, discard the buffer, and assert no done pulse.
REQ-034 SHALL present wr_ready=1 on the first cycle after rst deasserts.

Verification
REQ-035 SHALL be verified with INIT=0: load 3,2,1, then start -> dout rises at edge 3, falls at edge 5, rises at edge 6; done=1 for cycle 6 only; busy=0 from edge 6.
REQ-036 SHALL be verified as follows: write 9 entries with DEPTH=8 -> wr_ready low after the 8th accept, count=8, and the 9th value is not stored.
REQ-037 SHALL be verified with REPEAT=1: load 2,2 -> dout is a period-4 square wave, and done pulses every 4 cycles until stop, after which dout=INIT.
REQ-038 SHALL be verified as follows: load 0,0 -> dout toggles at edges 1 and 2, and count=2.
REQ-039 SHALL be verified as follows: start with count=0 -> busy stays 0; clr+wr_valid in the same cycle -> count=0.
REQ-040 SHALL be verified as follows: rst pulse mid-RUN between clock edges -> dout=INIT, count=0, busy=0 before the next edge.
